// File: rtl/mux_bus_pkg.sv
// Shared types and helpers for the multiplexed address/data bus master.
// Optional feature macro: MUX_BUS_TIMEOUT_EN (data-phase timeout abort).
package mux_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mux_bus_wait_ctr.sv
// Single cycle counter shared by address-phase index, wait-state count and timeout.
// Optional feature macro: MUX_BUS_TIMEOUT_EN (enables the timeout flag).
module mux_bus_wait_ctr #(
    parameter int ADDR_PH     = 1,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic addr_last,
    output logic wait_done,
    output logic tmo_done
);

    localparam int M1    = (ADDR_PH > WAIT_STATES + 1) ? ADDR_PH : WAIT_STATES + 1;
    localparam int CMAX  = (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
    localparam int CTR_W = $clog2(CMAX + 1);

    logic [CTR_W-1:0] cnt;

    // Saturates so a stuck slave cannot wrap the count back into range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    assign addr_last = (cnt == CTR_W'(ADDR_PH - 1));

    generate
        if (WAIT_STATES == 0) begin : g_no_ws
            assign wait_done = 1'b1;
        end else begin : g_ws
            assign wait_done = (cnt >= CTR_W'(WAIT_STATES));
        end
    endgenerate

`ifdef MUX_BUS_TIMEOUT_EN
    assign tmo_done = (cnt == CTR_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_done = 1'b0;
`endif

endmodule

// File: rtl/mux_bus_master.sv
// Master for the multiplexed address/data bus: ALE address phases, strobed data phase, response pulse.
// Optional feature macro: MUX_BUS_TIMEOUT_EN (abort the data phase after TIMEOUT_CYC cycles).
module mux_bus_master
    import mux_bus_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] bus_en,
    output logic              ale,
    output logic              bus_rw,
    output logic              bus_str,
    input  logic              bus_rdy
);

    localparam int ADDR_PH = ceil_div(ADDR_W, DATA_W);
    localparam int AP_W    = ADDR_PH * DATA_W;

    state_t            state, state_nxt;
    logic              wr_q, wr_now;
    logic [DATA_W-1:0] wdata_q;
    logic [AP_W-1:0]   addr_pad, addr_sh;
    logic              accept, done_ok;
    logic              addr_last, wait_done, tmo_done;

    logic              ready_d, rv_d, err_d, ale_d, rw_d, str_d;
    logic [DATA_W-1:0] rdata_d, out_d, en_d;

    assign accept   = req_valid && req_ready;
    assign addr_pad = AP_W'(req_addr);
    assign done_ok  = (state == ST_DATA) && wait_done && bus_rdy;
    assign wr_now   = (state == ST_IDLE) ? req_write : wr_q;

    mux_bus_wait_ctr #(
        .ADDR_PH     (ADDR_PH),
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_nxt != state),
        .en        (state != ST_IDLE),
        .addr_last (addr_last),
        .wait_done (wait_done),
        .tmo_done  (tmo_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_ADDR;
            ST_ADDR: if (addr_last) state_nxt = ST_DATA;
            ST_DATA: if (done_ok || tmo_done) state_nxt = ST_TURN;
            ST_TURN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Remaining address slices shift down so the next phase is always the low slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
            addr_sh <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            wdata_q <= req_wdata;
            addr_sh <= addr_pad >> DATA_W;
        end else if (state == ST_ADDR) begin
            addr_sh <= addr_sh >> DATA_W;
        end
    end

    // Outputs are decoded from the next state and registered, so pads see no decode glitches.
    always_comb begin
        ready_d = 1'b0;
        rv_d    = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        out_d   = '0;
        en_d    = '0;
        ale_d   = 1'b0;
        rw_d    = RW_READ;
        str_d   = 1'b0;
        case (state_nxt)
            ST_IDLE: ready_d = 1'b1;
            ST_ADDR: begin
                ale_d = 1'b1;
                en_d  = '1;
                rw_d  = wr_now ? RW_WRITE : RW_READ;
                out_d = (state == ST_IDLE) ? addr_pad[DATA_W-1:0] : addr_sh[DATA_W-1:0];
            end
            ST_DATA: begin
                str_d = 1'b1;
                rw_d  = wr_q ? RW_WRITE : RW_READ;
                if (wr_q) begin
                    out_d = wdata_q;
                    en_d  = '1;
                end
            end
            ST_TURN: begin
                rv_d    = 1'b1;
                rw_d    = wr_q ? RW_WRITE : RW_READ;
                err_d   = tmo_done && !done_ok;
                rdata_d = (done_ok && !wr_q) ? bus_in : '0;
            end
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            bus_out   <= '0;
            bus_en    <= '0;
            ale       <= 1'b0;
            bus_rw    <= RW_READ;
            bus_str   <= 1'b0;
        end else begin
            req_ready <= ready_d;
            rsp_valid <= rv_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            bus_out   <= out_d;
            bus_en    <= en_d;
            ale       <= ale_d;
            bus_rw    <= rw_d;
            bus_str   <= str_d;
        end
    end

endmodule

// File: tb/tb_mux_bus_master.sv
// Bench for mux_bus_master: 16-bit address over an 8-bit bus, two wait states.
// Expectations follow MUX_BUS_TIMEOUT_EN when it is defined for the build.
module tb_mux_bus_master;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int WS  = 2;
    localparam int TMO = 16;
    localparam int NPH = (AW + DW - 1) / DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [DW-1:0] bus_in, bus_out, bus_en;
    logic          ale, bus_rw, bus_str, bus_rdy;

    int checks = 0;
    int errors = 0;

    int            obs_cyc, obs_ale_n, obs_data_n;
    bit            obs_rsp, obs_rw_bad, obs_overlap, obs_aen_bad;
    logic [DW-1:0] obs_ale[8];
    logic [DW-1:0] obs_dout, obs_den, obs_rdata;
    logic          obs_err;

    mux_bus_master #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_in(bus_in), .bus_out(bus_out), .bus_en(bus_en),
        .ale(ale), .bus_rw(bus_rw), .bus_str(bus_str), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    // Reference: data phase lasts until both the wait states and the slave's delay have passed.
    function automatic int model_dcyc(input int rdy_low);
        int c;
        c = ((rdy_low > WS) ? rdy_low : WS) + 1;
`ifdef MUX_BUS_TIMEOUT_EN
        if (c > TMO) c = TMO;
`endif
        return c;
    endfunction

    function automatic bit model_tmo(input int rdy_low);
`ifdef MUX_BUS_TIMEOUT_EN
        return (((rdy_low > WS) ? rdy_low : WS) + 1) > TMO;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and reacts as a slave; records what the bus did.
    task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int rdy_low, input int max_cyc);
        int dn;
        int comp;
        comp = (rdy_low > WS) ? rdy_low : WS;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        obs_rsp = 0; obs_cyc = 0; obs_ale_n = 0; obs_data_n = 0;
        obs_rw_bad = 0; obs_overlap = 0; obs_aen_bad = 0;
        obs_dout = 'x; obs_den = 'x; obs_rdata = 'x; obs_err = 1'bx;
        for (int c = 1; c <= max_cyc; c++) begin
            dn = obs_data_n;
            if (ale === 1'b1) begin
                if (obs_ale_n < 8) obs_ale[obs_ale_n] = bus_out;
                obs_ale_n++;
                if (bus_en !== {DW{1'b1}}) obs_aen_bad = 1;
            end
            if (bus_str === 1'b1) begin
                obs_data_n++;
                obs_dout = bus_out;
                obs_den  = bus_en;
            end
            if ((ale === 1'b1 || bus_str === 1'b1) && bus_rw !== (wr ? 1'b0 : 1'b1)) obs_rw_bad = 1;
            if (ale === 1'b1 && bus_str === 1'b1) obs_overlap = 1;
            if (rsp_valid === 1'b1) begin
                obs_rsp = 1; obs_cyc = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
                break;
            end
            bus_rdy = (bus_str === 1'b1) && (dn >= rdy_low);
            bus_in  = (bus_str === 1'b1 && dn == comp) ? rd : DW'($urandom);
            step();
        end
        bus_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks += 9;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== '0)   begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0)   begin errors++; $display("FAIL rst_err got %b want 0", rsp_err); end
        if (bus_out !== '0)     begin errors++; $display("FAIL rst_bus_out got %h want 0", bus_out); end
        if (bus_en !== '0)      begin errors++; $display("FAIL rst_bus_en got %h want 0", bus_en); end
        if (ale !== 1'b0)       begin errors++; $display("FAIL rst_ale got %b want 0", ale); end
        if (bus_rw !== 1'b1)    begin errors++; $display("FAIL rst_bus_rw got %b want 1", bus_rw); end
        if (bus_str !== 1'b0)   begin errors++; $display("FAIL rst_str got %b want 0", bus_str); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_basic();
        do_xfer(1'b1, 16'h003C, 8'hA5, 8'h00, 0, 60);
        checks += 9;
        if (!obs_rsp) begin errors++; $display("FAIL wr_rsp no response seen"); end
        if (obs_ale_n != NPH) begin errors++; $display("FAIL wr_ale_n got %0d want %0d", obs_ale_n, NPH); end
        if (obs_ale[0] !== 8'h3C || obs_ale[1] !== 8'h00)
            begin errors++; $display("FAIL wr_addr got %h %h want 3c 00", obs_ale[0], obs_ale[1]); end
        if (obs_dout !== 8'hA5) begin errors++; $display("FAIL wr_data got %h want a5", obs_dout); end
        if (obs_den !== 8'hFF)  begin errors++; $display("FAIL wr_den got %h want ff", obs_den); end
        if (obs_cyc != NPH + model_dcyc(0) + 1)
            begin errors++; $display("FAIL wr_latency got %0d want %0d", obs_cyc, NPH + model_dcyc(0) + 1); end
        if (obs_err !== 1'b0 || obs_rdata !== 8'h00)
            begin errors++; $display("FAIL wr_rsp got err=%b rdata=%h want 0 00", obs_err, obs_rdata); end
        if (obs_rw_bad || obs_aen_bad) begin errors++; $display("FAIL wr_ctrl rw_bad=%0d aen_bad=%0d want 0", obs_rw_bad, obs_aen_bad); end
        step();
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_read();
        do_xfer(1'b0, 16'h12F0, 8'h00, 8'h5A, 0, 60);
        checks += 6;
        if (!obs_rsp) begin errors++; $display("FAIL rd_rsp no response seen"); end
        if (obs_ale[0] !== 8'hF0 || obs_ale[1] !== 8'h12)
            begin errors++; $display("FAIL rd_addr got %h %h want f0 12", obs_ale[0], obs_ale[1]); end
        if (obs_den !== 8'h00)   begin errors++; $display("FAIL rd_den got %h want 00", obs_den); end
        if (obs_rdata !== 8'h5A) begin errors++; $display("FAIL rd_rdata got %h want 5a", obs_rdata); end
        if (obs_err !== 1'b0)    begin errors++; $display("FAIL rd_err got %b want 0", obs_err); end
        if (obs_rw_bad)          begin errors++; $display("FAIL rd_rw bus_rw not read during transfer"); end
    endtask

    task automatic test_wait_states();
        int lows[2] = '{0, 5};
        for (int i = 0; i < 2; i++) begin
            do_xfer(1'b0, AW'($urandom), 8'h00, 8'hC3, lows[i], 60);
            checks += 2;
            if (obs_data_n != model_dcyc(lows[i]))
                begin errors++; $display("FAIL ws_dcyc low=%0d got %0d want %0d", lows[i], obs_data_n, model_dcyc(lows[i])); end
            if (obs_rdata !== 8'hC3)
                begin errors++; $display("FAIL ws_rdata low=%0d got %h want c3", lows[i], obs_rdata); end
        end
    endtask

    task automatic test_random();
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd, exp_rd;
        int            low;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom); a = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
            low = $urandom_range(0, 8);
            do_xfer(wr, a, wd, rd, low, 80);
            exp_rd = (wr || model_tmo(low)) ? '0 : rd;
            checks += 7;
            if (!obs_rsp || obs_cyc != NPH + model_dcyc(low) + 1)
                begin errors++; $display("FAIL rnd_lat n=%0d got %0d want %0d", n, obs_cyc, NPH + model_dcyc(low) + 1); end
            for (int k = 0; k < NPH; k++) begin
                checks++;
                if (obs_ale[k] !== DW'(a >> (k * DW)))
                    begin errors++; $display("FAIL rnd_addr n=%0d ph=%0d got %h want %h", n, k, obs_ale[k], DW'(a >> (k * DW))); end
            end
            if (obs_data_n != model_dcyc(low))
                begin errors++; $display("FAIL rnd_dcyc n=%0d got %0d want %0d", n, obs_data_n, model_dcyc(low)); end
            if (obs_den !== (wr ? 8'hFF : 8'h00))
                begin errors++; $display("FAIL rnd_den n=%0d got %h want %h", n, obs_den, wr ? 8'hFF : 8'h00); end
            if (wr && obs_dout !== wd)
                begin errors++; $display("FAIL rnd_dout n=%0d got %h want %h", n, obs_dout, wd); end
            if (obs_rdata !== exp_rd)
                begin errors++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, obs_rdata, exp_rd); end
            if (obs_err !== model_tmo(low))
                begin errors++; $display("FAIL rnd_err n=%0d got %b want %b", n, obs_err, model_tmo(low)); end
            if (obs_rw_bad || obs_overlap || obs_aen_bad)
                begin errors++; $display("FAIL rnd_ctrl n=%0d rw=%0d ovl=%0d aen=%0d want 0", n, obs_rw_bad, obs_overlap, obs_aen_bad); end
        end
    endtask

    task automatic test_timeout();
`ifdef MUX_BUS_TIMEOUT_EN
        do_xfer(1'b0, 16'hBEEF, 8'h00, 8'hFF, 1000, 60);
        checks += 4;
        if (!obs_rsp) begin errors++; $display("FAIL tmo_rsp no response within bound"); end
        if (obs_data_n != TMO) begin errors++; $display("FAIL tmo_dcyc got %0d want %0d", obs_data_n, TMO); end
        if (obs_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", obs_err); end
        if (obs_rdata !== 8'h00) begin errors++; $display("FAIL tmo_rdata got %h want 00", obs_rdata); end
`else
        do_xfer(1'b0, 16'hBEEF, 8'h00, 8'hFF, 1000, 100);
        checks += 2;
        if (obs_rsp) begin errors++; $display("FAIL stuck_rsp got rsp_valid want none"); end
        if (bus_str !== 1'b1) begin errors++; $display("FAIL stuck_str got %b want 1", bus_str); end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h4321; req_wdata = 8'h99;
        step();
        req_valid = 1'b0;
        bus_rdy = 1'b0;
        for (int i = 0; i < 10 && bus_str !== 1'b1; i++) step();
        checks++;
        if (bus_str !== 1'b1) begin errors++; $display("FAIL mid_reach bus_str got %b want 1", bus_str); end
        step();
        #2 rst = 1'b1;
        #1;
        checks += 7;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
        if (bus_str !== 1'b0)   begin errors++; $display("FAIL mid_str got %b want 0", bus_str); end
        if (bus_en !== '0)      begin errors++; $display("FAIL mid_en got %h want 00", bus_en); end
        if (bus_out !== '0)     begin errors++; $display("FAIL mid_out got %h want 00", bus_out); end
        if (bus_rw !== 1'b1)    begin errors++; $display("FAIL mid_rw got %b want 1", bus_rw); end
        if (ale !== 1'b0)       begin errors++; $display("FAIL mid_ale got %b want 0", ale); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rv got %b want 0", rsp_valid); end
        step();
        rst = 1'b0;
        seen = 0;
        bus_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid === 1'b1) seen++;
            step();
        end
        bus_rdy = 1'b0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mid_norsp got %0d responses want 0", seen); end
        do_xfer(1'b0, 16'h0A0B, 8'h00, 8'h3E, 1, 60);
        checks++;
        if (!obs_rsp || obs_rdata !== 8'h3E || obs_err !== 1'b0)
            begin errors++; $display("FAIL mid_after rsp=%0d rdata=%h err=%b want 1 3e 0", obs_rsp, obs_rdata, obs_err); end
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int rsp_c[2];
        int na, nr;
        bit ovl;
        logic [DW-1:0] rdv[2];
        na = 0; nr = 0; ovl = 0;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1111; req_wdata = 8'h22;
        bus_rdy = 1'b1; bus_in = 8'h77;
        for (int c = 0; c < 60; c++) begin
            if (na == 1) begin req_write = 1'b0; req_addr = 16'h3333; end
            if (na >= 2) req_valid = 1'b0;
            if (ale === 1'b1 && bus_str === 1'b1) ovl = 1;
            if (rsp_valid === 1'b1) begin
                if (nr < 2) begin rsp_c[nr] = c; rdv[nr] = rsp_rdata; end
                nr++;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                if (na < 2) acc[na] = c;
                na++;
            end
            step();
        end
        bus_rdy = 1'b0;
        req_valid = 1'b0;
        checks += 5;
        if (na != 2 || nr != 2) begin errors++; $display("FAIL b2b_count accepts=%0d rsps=%0d want 2 2", na, nr); end
        else begin
            if (acc[1] != rsp_c[0] + 1)
                begin errors++; $display("FAIL b2b_accept got cycle %0d want %0d", acc[1], rsp_c[0] + 1); end
            if (rdv[0] !== 8'h00) begin errors++; $display("FAIL b2b_wr_rdata got %h want 00", rdv[0]); end
            if (rdv[1] !== 8'h77) begin errors++; $display("FAIL b2b_rd_rdata got %h want 77", rdv[1]); end
        end
        if (ovl) begin errors++; $display("FAIL b2b_overlap ale and bus_str high together"); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bus_in = '0; bus_rdy = 1'b0;
        test_reset();
        test_write_basic();
        test_read();
        test_wait_states();
        test_random();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, time=%0t limit=300000", $time);
        $fatal(1);
    end

endmodule
